// File: rtl/bk_chk_pkg.sv
// Shared types and golden-model helpers for the Brent-Kung adder checker.
// Contents:
//   state_t     - checker control states IDLE / RUN / HALT
//   WIDTH_DEF   - default operand width
//   MAX_W       - widest operand the helper functions accept (WIDTH < MAX_W)
//   golden_add  - {cout, sum} of a + b + cin, one bit wider than the operands
//   carry_vec   - c[i] = carry out of bit i of a + b + cin
// Callers zero-extend narrower operands to MAX_W and slice the result, which
// is exact because the carry out of a zero-extended add is its next bit.
package bk_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int MAX_W     = 64;

  function automatic logic [MAX_W:0] golden_add(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic             cin);
    return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, cin};
  endfunction

  function automatic logic [MAX_W-1:0] carry_vec(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input logic             cin);
    logic [MAX_W-1:0] c;
    logic             cy;
    cy = cin;
    for (int i = 0; i < MAX_W; i++) begin
      c[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy);
      cy   = c[i];
    end
    return c;
  endfunction

endpackage

// File: rtl/bk_chk_delay.sv
// LATENCY-deep valid/data delay line with synchronous flush.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset (valid bits only)
//   flush              - clears every valid bit at the next edge, including
//                        the one being shifted in this cycle
//   in_vld / in_data   - sample entering the line
//   out_vld / out_data - sample leaving the line LATENCY cycles later
// LATENCY = 0 is a combinational pass-through.
module bk_chk_delay #(
  parameter int LATENCY = 0,
  parameter int DATA_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, flush};
      assign out_vld    = in_vld;
      assign out_data   = in_data;
    end else begin : g_pipe
      logic [LATENCY-1:0] vld_p;
      logic [DATA_W-1:0]  data_p [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= '0;
        end else if (flush) begin
          vld_p <= '0;
        end else begin
          vld_p[0] <= in_vld;
          for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
      end

      // data stages carry no reset; only the valid bits qualify them
      always_ff @(posedge clk) begin
        data_p[0] <= in_data;
        for (int i = 1; i < LATENCY; i++) data_p[i] <= data_p[i-1];
      end

      assign out_vld  = vld_p[LATENCY-1];
      assign out_data = data_p[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/bk_add_checker.sv
// Response checker for the Brent-Kung adder: recomputes a + b + cin, aligns
// it to the adder latency, compares with the adder outputs, keeps saturating
// pass/fail counts and captures the first failing vector.
// Optional feature macro: BK_CARRY_VEC_CHECK_EN (also checks res_c and adds
// the fail_cvec output).
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   start / stop            - control pulses (start wins over stop)
//   in_valid, a, b, cin     - operands as driven to the adder
//   res_sum, res_cout, res_c- adder outputs (res_c: per-bit carry outs)
//   busy, error             - in RUN / sticky mismatch flag
//   pass_cnt, fail_cnt      - saturating sample counters
//   fail_a/b/cin/exp/got    - first failing sample and its expected/got result
//   fail_cvec               - exp_c ^ res_c of the first failure (macro only)
module bk_add_checker
  import bk_chk_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int LATENCY     = 0,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] res_sum,
  input  logic             res_cout,
  input  logic [WIDTH-1:0] res_c,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic [WIDTH:0]   fail_exp,
`ifdef BK_CARRY_VEC_CHECK_EN
  output logic [WIDTH-1:0] fail_cvec,
`endif
  output logic [WIDTH:0]   fail_got
);

  localparam int DW = 2 * WIDTH + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state;
  logic             accept, flush, halt_go, cmp_vld, mism, cvec_bad;
  logic [DW-1:0]    ops_d;
  logic [WIDTH-1:0] a_d, b_d;
  logic             cin_d;
  logic [MAX_W:0]   gold_full;
  logic [WIDTH:0]   exp_res, got_res;
  logic             unused_hi;

  assign accept = in_valid && (state == RUN);
  // leaving RUN (or restarting) drops everything still in flight
  assign flush  = start || stop || halt_go;

  // operand capture -> compare stage (LATENCY cycles)
  bk_chk_delay #(.LATENCY(LATENCY), .DATA_W(DW)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_vld   (accept),
    .in_data  ({a, b, cin}),
    .out_vld  (cmp_vld),
    .out_data (ops_d)
  );

  // compare stage
  assign {a_d, b_d, cin_d} = ops_d;
  assign gold_full = golden_add(MAX_W'(a_d), MAX_W'(b_d), cin_d);
  assign exp_res   = gold_full[WIDTH:0];
  assign unused_hi = ^gold_full[MAX_W:WIDTH+1];
  assign got_res   = {res_cout, res_sum};

`ifdef BK_CARRY_VEC_CHECK_EN
  logic [MAX_W-1:0] cv_full;
  logic [WIDTH-1:0] exp_c;
  logic             unused_cv;
  assign cv_full   = carry_vec(MAX_W'(a_d), MAX_W'(b_d), cin_d);
  assign exp_c     = cv_full[WIDTH-1:0];
  assign unused_cv = ^cv_full[MAX_W-1:WIDTH];
  assign cvec_bad  = (exp_c != res_c);
`else
  logic unused_res_c;
  assign unused_res_c = ^res_c;
  assign cvec_bad     = 1'b0;
`endif

  assign mism    = (exp_res != got_res) || cvec_bad;
  assign halt_go = cmp_vld && mism && (HALT_ON_ERR != 0) && !stop;
  assign busy    = (state == RUN);

  // result stage: counters and capture close the compare cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      error    <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_cin <= 1'b0;
      fail_exp <= '0;
      fail_got <= '0;
`ifdef BK_CARRY_VEC_CHECK_EN
      fail_cvec <= '0;
`endif
    end else if (start) begin
      state    <= RUN;
      error    <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      fail_a   <= '0;
      fail_b   <= '0;
      fail_cin <= 1'b0;
      fail_exp <= '0;
      fail_got <= '0;
`ifdef BK_CARRY_VEC_CHECK_EN
      fail_cvec <= '0;
`endif
    end else begin
      if (stop)         state <= IDLE;
      else if (halt_go) state <= HALT;
      // a compare landing in the stop cycle is still counted
      if (cmp_vld) begin
        if (mism) begin
          fail_cnt <= sat_inc(fail_cnt);
          error    <= 1'b1;
          if (!error) begin
            fail_a   <= a_d;
            fail_b   <= b_d;
            fail_cin <= cin_d;
            fail_exp <= exp_res;
            fail_got <= got_res;
`ifdef BK_CARRY_VEC_CHECK_EN
            fail_cvec <= exp_c ^ res_c;
`endif
          end
        end else begin
          pass_cnt <= sat_inc(pass_cnt);
        end
      end
    end
  end

endmodule
